adc_osr_multi: RTL

Parameterised, synchronous, multi-channel successor to the single-channel ADC oversampler. It accumulates 4^m samples per channel and emits a left-aligned result of (DATA_W+MAX_MODE) bits, gaining +m bits of resolution. It sits between the SAR conversion core (time-interleaved, channel-tagged samples) and the bus or FIFO consumer. It adds per-channel accumulators, optional round-to-nearest, a valid/ready output handshake, overrun detection and flush.

---
 rtl/adc_osr_multi.sv | 124 ++++++++++++
 1 files changed

// File: rtl/adc_osr_multi.sv
// Multi-channel ADC oversampler: sums 4^m channel-tagged samples and emits a
// left-aligned (DATA_W+MAX_MODE)-bit result through a valid/ready register.
module adc_osr_multi #(
  parameter int DATA_W   = 12,
  parameter int MAX_MODE = 4,
  parameter int NCH      = 4,
  parameter int CH_W     = (NCH > 1) ? $clog2(NCH) : 1,
  parameter int OUT_W    = DATA_W + MAX_MODE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid_in,
  input  logic [CH_W-1:0]   sample_ch_in,
  input  logic [DATA_W-1:0] sample_in,
  input  logic [2:0]        osr_mode_in,
  input  logic              round_en_in,
  input  logic              flush_in,
  output logic              result_valid_out,
  input  logic              result_ready_in,
  output logic [OUT_W-1:0]  result_out,
  output logic [CH_W-1:0]   result_ch_out,
  output logic              overrun_out,
  input  logic              overrun_clr_in
);

  localparam int ACC_W = DATA_W + 2 * MAX_MODE;
  localparam int SUM_W = ACC_W + 1;
  localparam int CNT_W = 2 * MAX_MODE + 1;
  localparam logic [2:0]    MAX_MODE_V = 3'(MAX_MODE);
  localparam logic [CH_W:0] NCH_V      = (CH_W + 1)'(NCH);

  logic [ACC_W-1:0] acc     [NCH];
  logic [CNT_W-1:0] cnt     [NCH];
  logic [2:0]       mode_r  [NCH];
  logic             round_r [NCH];

  logic             accept;
  logic [CH_W-1:0]  ch_idx;
  logic [2:0]       mode_clamp;
  logic             idle;
  logic [2:0]       mode_eff;
  logic             round_eff;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] cnt_target;
  logic             last;
  logic [SUM_W-1:0] rnd_add;
  logic [SUM_W-1:0] sum_rnd;
  logic [OUT_W-1:0] result_calc;
  logic             complete;

  // Only one sample arrives per cycle, so the datapath is shared and steered
  // to the addressed channel; an idle channel takes its mode from the inputs.
  always_comb begin
    accept      = sample_valid_in && !flush_in && ({1'b0, sample_ch_in} < NCH_V);
    ch_idx      = accept ? sample_ch_in : '0;
    mode_clamp  = (osr_mode_in > MAX_MODE_V) ? 3'd0 : osr_mode_in;
    idle        = (cnt[ch_idx] == '0);
    mode_eff    = idle ? mode_clamp : mode_r[ch_idx];
    round_eff   = idle ? round_en_in : round_r[ch_idx];
    acc_base    = idle ? '0 : acc[ch_idx];
    acc_sum     = acc_base + ACC_W'(sample_in);
    cnt_next    = (idle ? '0 : cnt[ch_idx]) + CNT_W'(1);
    cnt_target  = CNT_W'(1) << {mode_eff, 1'b0};
    last        = (cnt_next == cnt_target);
    rnd_add     = '0;
    if (round_eff && (mode_eff != 3'd0)) begin
      rnd_add = SUM_W'(1) << (mode_eff - 3'd1);
    end
    sum_rnd     = {1'b0, acc_sum} + rnd_add;
    // Drop m LSBs, then left-align the DATA_W+m bit quotient.
    result_calc = OUT_W'((sum_rnd >> mode_eff) << (MAX_MODE_V - mode_eff));
    complete    = accept && last;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        acc[i]     <= '0;
        cnt[i]     <= '0;
        mode_r[i]  <= '0;
        round_r[i] <= 1'b0;
      end
    end else if (flush_in) begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
      end
    end else if (accept) begin
      if (idle) begin
        mode_r[ch_idx]  <= mode_clamp;
        round_r[ch_idx] <= round_en_in;
      end
      acc[ch_idx] <= acc_sum;
      cnt[ch_idx] <= last ? '0 : cnt_next;
    end
  end

  // A completion reloads the output register whenever the current result is
  // gone or leaving this cycle; otherwise it is dropped and flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_valid_out <= 1'b0;
      result_out       <= '0;
      result_ch_out    <= '0;
      overrun_out      <= 1'b0;
    end else begin
      if (complete && (!result_valid_out || result_ready_in)) begin
        result_valid_out <= 1'b1;
        result_out       <= result_calc;
        result_ch_out    <= ch_idx;
      end else if (result_valid_out && result_ready_in) begin
        result_valid_out <= 1'b0;
      end

      if (complete && result_valid_out && !result_ready_in) begin
        overrun_out <= 1'b1;
      end else if (overrun_clr_in) begin
        overrun_out <= 1'b0;
      end
    end
  end

endmodule
